// File: rtl/decoder_3to8_if.sv
// ----------------------------------------------------------------------------
// decoder_3to8_if
// Groups the decode request (en, a_in) and the registered response
// (a_out, out_valid) of the 3-to-8 decoder. Clock and reset stay outside.
//   master : drives en/a_in, observes a_out/out_valid (the requester)
//   slave  : the decoder itself
// ----------------------------------------------------------------------------
interface decoder_3to8_if;
    logic       en;
    logic [2:0] a_in;
    logic [7:0] a_out;
    logic       out_valid;

    modport master (output en, output a_in, input a_out, input out_valid);
    modport slave  (input en, input a_in, output a_out, output out_valid);
endinterface

// File: rtl/decoder_3to8.sv
// ----------------------------------------------------------------------------
// decoder_3to8
// Registered 3-to-8 binary decoder with one cycle of latency.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset (priority over en/a_in)
//   bus.en       : decode enable; 0 forces all outputs inactive
//   bus.a_in     : 3-bit code
//   bus.a_out    : one-hot word (one-cold when ACTIVE_LOW=1)
//   bus.out_valid: a_out holds the decode of an enabled code
// Parameter ACTIVE_LOW selects output polarity.
// ----------------------------------------------------------------------------
module decoder_3to8 #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    decoder_3to8_if.slave bus
);
    // Polarity mask: XOR with this turns the one-hot word into its active level.
    localparam logic [7:0] POL      = {8{ACTIVE_LOW}};
    localparam logic [7:0] INACTIVE = POL;

    logic [7:0] w_hot;
    logic [7:0] r_out;
    logic       r_vld;

    // One comparator per output line.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_line
            assign w_hot[g] = (bus.a_in == 3'(g));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= INACTIVE;
            r_vld <= 1'b0;
        end else if (bus.en) begin
            r_out <= w_hot ^ POL;
            r_vld <= 1'b1;
        end else begin
            r_out <= INACTIVE;
            r_vld <= 1'b0;
        end
    end

    assign bus.a_out     = r_out;
    assign bus.out_valid = r_vld;
endmodule

// File: tb/tb_decoder_3to8.sv
// ----------------------------------------------------------------------------
// tb_decoder_3to8
// Drives an active-high and an active-low decoder with identical stimulus.
// The driver pushes the expected response for each clock edge into a queue;
// a monitor on the falling edge pops and compares both instances.
// ----------------------------------------------------------------------------
module tb_decoder_3to8;
    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       vld;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] a_in;
    exp_t       q[$];
    int         tests  = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    decoder_3to8_if if_hi ();
    decoder_3to8_if if_lo ();

    assign if_hi.en   = en;
    assign if_hi.a_in = a_in;
    assign if_lo.en   = en;
    assign if_lo.a_in = a_in;

    decoder_3to8 #(.ACTIVE_LOW(1'b0)) u_hi (.clk(clk), .rst_n(rst_n), .bus(if_hi.slave));
    decoder_3to8 #(.ACTIVE_LOW(1'b1)) u_lo (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));

    // Reference: output value is 2**code when selected, nothing otherwise.
    function automatic exp_t model(input logic r, input logic e, input logic [2:0] a);
        exp_t x;
        int   v;
        v = (r && e) ? (2 ** int'(a)) : 0;
        x.hi  = 8'(v);
        x.lo  = 8'(255 - v);
        x.vld = r && e;
        return x;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [2:0] a);
        rst_n = r;
        en    = e;
        a_in  = a;
        @(posedge clk);
        q.push_back(model(r, e, a));
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("a_out_hi",      if_hi.a_out, e.hi);
            chk("valid_hi",      8'(if_hi.out_valid), 8'(e.vld));
            chk("a_out_lo",      if_lo.a_out, e.lo);
            chk("valid_lo",      8'(if_lo.out_valid), 8'(e.vld));
            // Invariant: one active bit when valid, none otherwise.
            chk("onehot_hi",     8'($countones(if_hi.a_out)), e.vld ? 8'd1 : 8'd0);
            chk("onecold_lo",    8'($countones(~if_lo.a_out)), e.vld ? 8'd1 : 8'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        a_in  = 3'b101;
        #1;
        // Reset held with a live request.
        cyc(1'b0, 1'b1, 3'b101);
        cyc(1'b0, 1'b1, 3'b101);
        // Full sweep, back to back.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i));
        // Enable gating.
        cyc(1'b1, 1'b0, 3'b011);
        cyc(1'b1, 1'b1, 3'b011);
        // Reset mid-operation.
        cyc(1'b1, 1'b1, 3'b110);
        cyc(1'b0, 1'b1, 3'b110);
        cyc(1'b1, 1'b1, 3'b110);
        cyc(1'b1, 1'b1, 3'b110);
        // Polarity corners.
        cyc(1'b1, 1'b1, 3'b000);
        cyc(1'b1, 1'b1, 3'b111);
        // Random traffic with occasional reset and disabled cycles.
        for (int i = 0; i < 1000; i++)
            cyc(($urandom_range(31) != 0), ($urandom_range(3) != 0), 3'($urandom_range(7)));
        // Drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/decoder_3to8.md
Name: decoder_3to8

Overview:
- Registered 3-to-8 line binary decoder: 3-bit code in, one-hot 8-bit word out.
- Output bit `a_out[n]` is active exactly when the registered code equals n.
- Used wherever a select/index must drive one of eight enables, e.g. bank select, chip select, mux one-hot control.
- Single clock domain; one-cycle latency; optional active-low output polarity.

Parameters:
- ACTIVE_LOW, default 0, output polarity.
  - 0: the selected bit is 1 and all others are 0.
  - 1: the selected bit is 0 and all others are 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  decode enable; when 0, all outputs go inactive.
- a_in  input  3  binary code to decode.
- a_out  output  8  decoded word (one-hot, or one-cold when ACTIVE_LOW=1).
- out_valid  output  1  high when a_out carries a decode of an enabled input.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. It is sampled only on the rising edge of clk and has no asynchronous path.
- All state updates occur on the rising edge of clk; there is no combinational path from inputs to outputs.
- Reset: if rst_n==0 at a rising edge, the following apply, with reset taking priority over en and a_in:
  - a_out <= all-inactive: 8'h00 when ACTIVE_LOW=0, 8'hFF when ACTIVE_LOW=1.
  - out_valid <= 0.
- Decode: if rst_n==1 and en==1 at a rising edge:
  - a_out <= (8'b1 << a_in) when ACTIVE_LOW=0, or the bitwise inverse of that when ACTIVE_LOW=1.
  - out_valid <= 1.
- Disabled: if rst_n==1 and en==0 at a rising edge, a_out <= all-inactive and out_valid <= 0.
- Latency: exactly 1 clock from sampled (en, a_in) to a_out/out_valid.
- Throughput: a new code may be applied every cycle. Back-to-back codes produce back-to-back outputs with no bubbles.
- Invariants:
  - When out_valid==1, exactly one bit of a_out is active.
  - When out_valid==0, no bit of a_out is active.
- Full range: all 8 codes 3'b000..3'b111 are legal; no wrap-around or out-of-range case exists.
- Unknown inputs: if a_in contains X/Z while en==1, output content is undefined. Verification must not drive this case.
- Reset mid-stream: asserting rst_n low on any edge clears the outputs on that edge, regardless of the code being decoded. The first decode after release appears one cycle after the first edge with rst_n==1 and en==1.
- Held input: a_out stays constant while a_in and en are held, with no glitch on the registered outputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, a_in=3'b101 -> a_out=8'b00000000, out_valid=0 throughout (ACTIVE_LOW=0).
- Full sweep: rst_n=1, en=1, a_in=0..7 on consecutive cycles. Each result appears one cycle after its code is applied:
  - a_out follows 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000.
  - out_valid=1 on each of those cycles.
- Enable gating: a_in=3'b011 with en=0 -> a_out=8'h00, out_valid=0. Raise en=1 -> next cycle a_out=8'b00001000, out_valid=1.
- Reset mid-operation: decoding a_in=3'b110 (a_out=8'b01000000), then pull rst_n=0 for one edge -> a_out=8'h00, out_valid=0. Release -> a_out=8'b01000000 one cycle later.
- ACTIVE_LOW=1 build:
  - Reset -> a_out=8'hFF.
  - a_in=3'b000 -> a_out=8'b11111110.
  - a_in=3'b111 -> a_out=8'b01111111.
- One-hot checker: random a_in/en over 1000 cycles, with a scoreboard comparing against 1<<a_in delayed by one cycle -> zero mismatches. Exactly one active bit whenever out_valid=1, none otherwise.
